// File: rtl/sr_pkg.sv
// Shared types and command encodings for the SR storage stage.
package sr_pkg;

    typedef enum logic [1:0] {
        HOLD0 = 2'b00,
        HOLD1 = 2'b01,
        ERROR = 2'b10
    } sr_state_t;

    // Command code is {S,R}.
    localparam logic [1:0] CMD_HOLD   = 2'b00;
    localparam logic [1:0] CMD_RESET  = 2'b01;
    localparam logic [1:0] CMD_SET    = 2'b10;
    localparam logic [1:0] CMD_FORBID = 2'b11;

endpackage

// File: rtl/sr_latch_stage_if.sv
// Command inputs and observable outputs of the SR storage stage.
interface sr_latch_stage_if #(
    parameter int CNT_W = 8
);
    logic             S;
    logic             R;
    logic             CLR;
    logic             Q;
    logic             QN;
    logic             ERR;
    logic [CNT_W-1:0] SET_CNT;
    logic [CNT_W-1:0] RST_CNT;

    modport master (
        output S, R, CLR,
        input  Q, QN, ERR, SET_CNT, RST_CNT
    );

    modport slave (
        input  S, R, CLR,
        output Q, QN, ERR, SET_CNT, RST_CNT
    );
endinterface

// File: rtl/sr_input_filter.sv
// Run-length filter: a command is accepted once it has been seen on FILT
// consecutive edges, and keeps being accepted while it stays unchanged.
module sr_input_filter
    import sr_pkg::*;
#(
    parameter int FILT = 2
) (
    input  logic       CK,
    input  logic       RN,
    input  logic [1:0] cmd,
    output logic       acc_valid,
    output logic [1:0] acc_cmd
);
    localparam int                RUN_W   = $clog2(FILT + 1);
    localparam logic [RUN_W-1:0]  RUN_MAX = RUN_W'(FILT);

    logic [1:0]       last_cmd;
    logic [RUN_W-1:0] run;
    logic [RUN_W-1:0] run_nxt;

    // Run length after this edge, saturating at FILT; a changed command restarts at 1.
    always_comb begin
        run_nxt = RUN_W'(1);
        if (cmd == last_cmd) begin
            run_nxt = (run == RUN_MAX) ? RUN_MAX : run + RUN_W'(1);
        end
    end

    // Filter registers; reset discards any partial run.
    always_ff @(posedge CK) begin
        if (!RN) begin
            last_cmd <= CMD_HOLD;
            run      <= '0;
        end else begin
            last_cmd <= cmd;
            run      <= run_nxt;
        end
    end

    assign acc_valid = (run_nxt == RUN_MAX);
    assign acc_cmd   = cmd;
endmodule

// File: rtl/sr_latch_stage.sv
// Clocked SR storage stage: filtered S/R commands drive a HOLD0/HOLD1/ERROR
// FSM, with sticky error flag and saturating transition counters.
module sr_latch_stage
    import sr_pkg::*;
#(
    parameter int CNT_W = 8,
    parameter int FILT  = 2
) (
    input  logic            CK,
    input  logic            RN,
    sr_latch_stage_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    sr_state_t        state;
    sr_state_t        state_nxt;
    logic             q_reg;
    logic             q_nxt;
    logic             err_reg;
    logic             set_inc;
    logic             rst_inc;
    logic [CNT_W-1:0] set_cnt;
    logic [CNT_W-1:0] rst_cnt;
    logic             acc_valid;
    logic [1:0]       acc_cmd;

    sr_input_filter #(
        .FILT (FILT)
    ) u_filter (
        .CK        (CK),
        .RN        (RN),
        .cmd       ({bus.S, bus.R}),
        .acc_valid (acc_valid),
        .acc_cmd   (acc_cmd)
    );

    // State, Q, error flag and counters; CLR wins over any accepted command.
    always_ff @(posedge CK) begin
        if (!RN) begin
            state   <= HOLD0;
            q_reg   <= 1'b0;
            err_reg <= 1'b0;
            set_cnt <= '0;
            rst_cnt <= '0;
        end else begin
            state   <= state_nxt;
            q_reg   <= q_nxt;
            err_reg <= (state_nxt == ERROR);
            if (bus.CLR) begin
                set_cnt <= '0;
                rst_cnt <= '0;
            end else begin
                if (set_inc && set_cnt != CNT_MAX) set_cnt <= set_cnt + 1'b1;
                if (rst_inc && rst_cnt != CNT_MAX) rst_cnt <= rst_cnt + 1'b1;
            end
        end
    end

    // Next state: CLR re-derives the hold state from Q; ERROR ignores commands.
    always_comb begin
        state_nxt = state;
        if (bus.CLR) begin
            state_nxt = q_reg ? HOLD1 : HOLD0;
        end else if (acc_valid) begin
            case (state)
                HOLD0: begin
                    if (acc_cmd == CMD_SET)         state_nxt = HOLD1;
                    else if (acc_cmd == CMD_FORBID) state_nxt = ERROR;
                end
                HOLD1: begin
                    if (acc_cmd == CMD_RESET)       state_nxt = HOLD0;
                    else if (acc_cmd == CMD_FORBID) state_nxt = ERROR;
                end
                default: state_nxt = state;
            endcase
        end
    end

    // Next Q and counter increments; only real 0->1 / 1->0 moves are counted.
    always_comb begin
        q_nxt   = q_reg;
        set_inc = 1'b0;
        rst_inc = 1'b0;
        if (!bus.CLR && acc_valid) begin
            if (state == HOLD0 && acc_cmd == CMD_SET) begin
                q_nxt   = 1'b1;
                set_inc = 1'b1;
            end else if (state == HOLD1 && acc_cmd == CMD_RESET) begin
                q_nxt   = 1'b0;
                rst_inc = 1'b1;
            end
        end
    end

    assign bus.Q       = q_reg;
    assign bus.QN      = ~q_reg;
    assign bus.ERR     = err_reg;
    assign bus.SET_CNT = set_cnt;
    assign bus.RST_CNT = rst_cnt;
endmodule

// File: tb/tb_sr_latch_stage.sv
// Bench for sr_latch_stage: windowed behavioural model checked every edge,
// plus directed sequences with literal expectations.
module tb_sr_latch_stage;
    localparam int CW   = 2;
    localparam int FL   = 2;
    localparam int MAXC = (1 << CW) - 1;

    logic CK;
    logic RN;
    int   n_checks = 0;
    int   n_fail   = 0;

    sr_latch_stage_if #(.CNT_W(CW)) bus ();

    sr_latch_stage #(
        .CNT_W (CW),
        .FILT  (FL)
    ) dut (
        .CK  (CK),
        .RN  (RN),
        .bus (bus)
    );

    initial begin
        CK = 1'b0;
        forever #5 CK = ~CK;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the last FL sampled commands since reset; accepted when all equal.
    logic [1:0] hist [FL];
    int         h_len = 0;
    logic       m_q = 1'b0;
    logic       m_err = 1'b0;
    int         m_sc = 0;
    int         m_rc = 0;
    logic [1:0] cmd_s;
    logic       acc;

    always @(posedge CK) begin
        cmd_s = {bus.S, bus.R};
        if (!RN) begin
            m_q = 1'b0; m_err = 1'b0; m_sc = 0; m_rc = 0; h_len = 0;
        end else begin
            for (int i = FL - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = cmd_s;
            if (h_len < FL) h_len++;
            acc = (h_len == FL);
            for (int i = 1; i < FL; i++) if (hist[i] != hist[0]) acc = 1'b0;
            if (bus.CLR) begin
                m_err = 1'b0; m_sc = 0; m_rc = 0;
            end else if (acc && !m_err) begin
                if (cmd_s == 2'b10 && !m_q) begin
                    m_q = 1'b1;
                    if (m_sc < MAXC) m_sc++;
                end else if (cmd_s == 2'b01 && m_q) begin
                    m_q = 1'b0;
                    if (m_rc < MAXC) m_rc++;
                end else if (cmd_s == 2'b11) begin
                    m_err = 1'b1;
                end
            end
        end
        #1;
        chk("model_q",   int'(bus.Q),   int'(m_q));
        chk("model_qn",  int'(bus.QN),  int'(!m_q));
        chk("model_err", int'(bus.ERR), int'(m_err));
        chk("model_set", int'(bus.SET_CNT), m_sc);
        chk("model_rst", int'(bus.RST_CNT), m_rc);
    end

    // Apply one cycle of inputs; returns at the negedge after the sampling edge.
    task automatic step(input logic s, input logic r, input logic c, input logic rn_v);
        bus.S   = s;
        bus.R   = r;
        bus.CLR = c;
        RN      = rn_v;
        @(negedge CK);
    endtask

    initial begin
        RN = 1'b0; bus.S = 1'b0; bus.R = 1'b0; bus.CLR = 1'b0;

        // Reset then set
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("rst_q",   int'(bus.Q),   0);
        chk("rst_qn",  int'(bus.QN),  1);
        chk("rst_err", int'(bus.ERR), 0);
        chk("rst_set", int'(bus.SET_CNT), 0);
        chk("rst_rst", int'(bus.RST_CNT), 0);
        step(1, 0, 0, 1);
        chk("set_first_edge_q", int'(bus.Q), 0);
        step(1, 0, 0, 1);
        chk("set_second_edge_q",   int'(bus.Q), 1);
        chk("set_second_edge_cnt", int'(bus.SET_CNT), 1);
        step(1, 0, 0, 1);
        chk("set_held_cnt", int'(bus.SET_CNT), 1);

        // Back to Q=0, clear counters, then glitch rejection
        step(0, 1, 0, 1);
        step(0, 1, 0, 1);
        chk("reset_q",   int'(bus.Q), 0);
        chk("reset_cnt", int'(bus.RST_CNT), 1);
        step(0, 0, 1, 1);
        step(0, 0, 0, 1);
        chk("clr_cnt", int'(bus.RST_CNT), 0);
        step(1, 0, 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("glitch_s_q",   int'(bus.Q), 0);
        chk("glitch_s_cnt", int'(bus.SET_CNT), 0);
        step(1, 0, 0, 1);
        step(1, 0, 0, 1);
        chk("set_again_q", int'(bus.Q), 1);
        step(0, 1, 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("glitch_r_q",   int'(bus.Q), 1);
        chk("glitch_r_cnt", int'(bus.RST_CNT), 0);

        // Forbidden input while Q=1
        step(1, 1, 0, 1);
        chk("forbid_first_err", int'(bus.ERR), 0);
        step(1, 1, 0, 1);
        chk("forbid_err", int'(bus.ERR), 1);
        chk("forbid_q",   int'(bus.Q), 1);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 1);
        chk("error_ignores_r_q", int'(bus.Q), 1);
        chk("error_sticky",      int'(bus.ERR), 1);
        step(0, 0, 1, 1);
        chk("clr_err", int'(bus.ERR), 0);
        chk("clr_q",   int'(bus.Q), 1);
        chk("clr_set", int'(bus.SET_CNT), 0);
        step(0, 1, 0, 1);
        step(0, 1, 0, 1);
        chk("hold1_after_clr_q", int'(bus.Q), 0);
        chk("hold1_after_clr_r", int'(bus.RST_CNT), 1);

        // Re-error with FORBID held through CLR
        step(1, 1, 0, 1);
        step(1, 1, 0, 1);
        chk("reerr_first", int'(bus.ERR), 1);
        step(1, 1, 1, 1);
        chk("reerr_clr_edge", int'(bus.ERR), 0);
        step(1, 1, 0, 1);
        chk("reerr_next_edge", int'(bus.ERR), 1);
        step(0, 0, 1, 1);
        chk("reerr_cleared", int'(bus.ERR), 0);

        // Saturation: 5 accepted SET/RESET pairs with 2-bit counters
        for (int p = 1; p <= 5; p++) begin
            step(1, 0, 0, 1);
            step(1, 0, 0, 1);
            step(0, 1, 0, 1);
            step(0, 1, 0, 1);
            if (p == 3) begin
                chk("sat_p3_set", int'(bus.SET_CNT), 3);
                chk("sat_p3_rst", int'(bus.RST_CNT), 3);
            end
        end
        chk("sat_set", int'(bus.SET_CNT), 3);
        chk("sat_rst", int'(bus.RST_CNT), 3);
        chk("sat_q",   int'(bus.Q), 0);

        // CLR discards a command accepted on the same edge; held command re-accepts
        step(1, 0, 0, 1);
        step(1, 0, 0, 1);
        chk("pre_clr_q",  int'(bus.Q), 1);
        chk("sat_hold",   int'(bus.SET_CNT), 3);
        step(0, 1, 0, 1);
        step(0, 1, 1, 1);
        chk("clr_discard_q", int'(bus.Q), 1);
        step(0, 1, 0, 1);
        chk("reaccept_q",   int'(bus.Q), 0);
        chk("reaccept_cnt", int'(bus.RST_CNT), 1);

        // Reset mid-run
        step(1, 0, 0, 1);
        step(1, 0, 0, 0);
        chk("midrst_q",   int'(bus.Q), 0);
        chk("midrst_cnt", int'(bus.RST_CNT), 0);
        step(1, 0, 0, 1);
        chk("midrst_rel1_q", int'(bus.Q), 0);
        step(1, 0, 0, 1);
        chk("midrst_rel2_q",   int'(bus.Q), 1);
        chk("midrst_rel2_cnt", int'(bus.SET_CNT), 1);

        step(0, 0, 0, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
